// File: rtl/dma_write_sequencer_pkg.sv
// Shared constants, register indices and FSM states
// for the upstream DMA write sequencer.
package dma_pkg;

    localparam int QW_PER_TLP = 16;
    localparam int DATA_OFFSET = 64;
    localparam int CNT_W = 16;
    localparam int BEAT_W = $clog2(QW_PER_TLP);
    localparam int LEN_W = 10;

    localparam logic [63:0] TOKEN = 64'hCAFEF00DC0DEFACE;

    localparam logic DMABASE_IDX = 1'b0;
    localparam logic DMACTRL_IDX = 1'b1;

    localparam logic [LEN_W-1:0] DATA_LEN_DW = LEN_W'(2 * QW_PER_TLP);
    localparam logic [LEN_W-1:0] TOKEN_LEN_DW = LEN_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        DREQ,
        DBEAT,
        TREQ,
        TBEAT
    } state_t;

endpackage

// File: rtl/dma_write_sequencer_if.sv
// TX-path bundle between the sequencer and the
// arbiter it shares with the completion generator.
interface dma_write_sequencer_if;
    import dma_pkg::*;

    logic             tx_req;
    logic             tx_gnt;
    logic [31:0]      tx_addr;
    logic [LEN_W-1:0] tx_len_dw;
    logic [63:0]      tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_sop;
    logic             tx_eop;

    modport master (
        output tx_req, tx_addr, tx_len_dw, tx_data,
        output tx_valid, tx_sop, tx_eop,
        input  tx_gnt, tx_ready
    );

    modport slave (
        input  tx_req, tx_addr, tx_len_dw, tx_data,
        input  tx_valid, tx_sop, tx_eop,
        output tx_gnt, tx_ready
    );

endinterface

// File: rtl/dma_write_sequencer.sv
// Issues DMACTRL x 128-byte write TLPs from the source
// FIFO, then a completion-token write at DMABASE.
module dma_write_sequencer
    import dma_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rstn,
    input  logic                  reg_wr,
    input  logic                  reg_idx,
    input  logic [31:0]           reg_data,
    input  logic [63:0]           src_data,
    input  logic [7:0]            src_level,
    output logic                  src_rd,
    dma_write_sequencer_if.master tx,
    output logic                  busy,
    output logic [31:0]           done_cnt,
    output logic                  err_busy_wr
);

    state_t state, state_nxt;

    logic [31:0]      base_q;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] remaining_q;
    logic [BEAT_W-1:0] beat_q;

    logic start;
    logic accept;
    logic last_beat;
    logic have_data;

    assign busy = (state != IDLE);
    assign start = reg_wr && !busy
                && (reg_idx == DMACTRL_IDX)
                && (reg_data[CNT_W-1:0] != '0);
    assign accept = tx.tx_valid && tx.tx_ready;
    assign last_beat = (beat_q == BEAT_W'(QW_PER_TLP - 1));
    // Only request once a whole TLP body is buffered.
    assign have_data = (src_level >= 8'(QW_PER_TLP));

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            base_q      <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            done_cnt    <= '0;
            err_busy_wr <= 1'b0;
        end else begin
            if (reg_wr && busy) begin
                err_busy_wr <= 1'b1;
            end
            if (reg_wr && !busy && (reg_idx == DMABASE_IDX)) begin
                base_q <= {reg_data[31:3], 3'b000};
            end
            if (start) begin
                addr_q      <= base_q + 32'(DATA_OFFSET);
                remaining_q <= reg_data[CNT_W-1:0];
                beat_q      <= '0;
            end
            if ((state == DBEAT) && accept) begin
                if (last_beat) begin
                    beat_q      <= '0;
                    addr_q      <= addr_q + 32'(8 * QW_PER_TLP);
                    remaining_q <= remaining_q - CNT_W'(1);
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
            if ((state == TBEAT) && accept) begin
                done_cnt <= done_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        tx.tx_req    = 1'b0;
        tx.tx_addr   = '0;
        tx.tx_len_dw = '0;
        tx.tx_data   = '0;
        tx.tx_valid  = 1'b0;
        tx.tx_sop    = 1'b0;
        tx.tx_eop    = 1'b0;
        src_rd       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DREQ;
                end
            end
            DREQ: begin
                tx.tx_req    = have_data;
                tx.tx_addr   = addr_q;
                tx.tx_len_dw = DATA_LEN_DW;
                if (have_data && tx.tx_gnt) begin
                    state_nxt = DBEAT;
                end
            end
            DBEAT: begin
                tx.tx_valid  = 1'b1;
                tx.tx_addr   = addr_q;
                tx.tx_len_dw = DATA_LEN_DW;
                tx.tx_data   = src_data;
                tx.tx_sop    = (beat_q == '0);
                tx.tx_eop    = last_beat;
                src_rd       = tx.tx_ready;
                if (tx.tx_ready && last_beat) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_nxt = TREQ;
                    end else begin
                        state_nxt = DREQ;
                    end
                end
            end
            TREQ: begin
                tx.tx_req    = 1'b1;
                tx.tx_addr   = base_q;
                tx.tx_len_dw = TOKEN_LEN_DW;
                if (tx.tx_gnt) begin
                    state_nxt = TBEAT;
                end
            end
            TBEAT: begin
                tx.tx_valid  = 1'b1;
                tx.tx_addr   = base_q;
                tx.tx_len_dw = TOKEN_LEN_DW;
                tx.tx_data   = TOKEN;
                tx.tx_sop    = 1'b1;
                tx.tx_eop    = 1'b1;
                if (tx.tx_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_write_sequencer.sv
// Randomised scoreboard bench: jobs queue expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_dma_write_sequencer;
    import dma_pkg::*;

    typedef logic [127:0] w_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [9:0]  len;
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_wr = 1'b0;
    logic        reg_idx = 1'b0;
    logic [31:0] reg_data = '0;
    logic [63:0] src_data;
    logic [7:0]  src_level;
    logic        src_rd;
    logic        busy;
    logic [31:0] done_cnt;
    logic        err_busy_wr;

    dma_write_sequencer_if tx_if ();

    dma_write_sequencer dut (
        .clk_in      (clk_in),
        .rstn        (rstn),
        .reg_wr      (reg_wr),
        .reg_idx     (reg_idx),
        .reg_data    (reg_data),
        .src_data    (src_data),
        .src_level   (src_level),
        .src_rd      (src_rd),
        .tx          (tx_if),
        .busy        (busy),
        .done_cnt    (done_cnt),
        .err_busy_wr (err_busy_wr)
    );

    always #5 clk_in = ~clk_in;

    beat_t       exp_q[$];
    logic [63:0] src_q[$];
    logic [63:0] late_q[$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rd = 0;
    int          beat_no = 0;
    logic        gnt_nxt = 1'b0;
    logic        pop_pend = 1'b0;
    logic        in_tlp = 1'b0;
    logic        have_hold = 1'b0;
    logic        rdy_rand = 1'b0;
    beat_t       held;
    beat_t       mon_cur;
    beat_t       mon_exp;
    logic [31:0] m_done = '0;
    logic [31:0] m_base = '0;

    function automatic void chk(input string name, input w_t act, input w_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic beat_t cur_beat();
        return {tx_if.tx_addr, tx_if.tx_len_dw, tx_if.tx_data,
                tx_if.tx_sop, tx_if.tx_eop};
    endfunction

    // Monitor and arbiter decision, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (!rstn) begin
            gnt_nxt   = 1'b0;
            pop_pend  = 1'b0;
            in_tlp    = 1'b0;
            have_hold = 1'b0;
            beat_no   = 0;
        end else begin
            mon_cur = cur_beat();
            if (in_tlp) begin
                chk("no_gap", w_t'(tx_if.tx_valid), w_t'(1));
            end
            if (have_hold) begin
                chk("stall_hold", w_t'({tx_if.tx_valid, mon_cur}),
                    w_t'({1'b1, held}));
            end
            have_hold = tx_if.tx_valid && !tx_if.tx_ready;
            held = mon_cur;
            if (!tx_if.tx_gnt && tx_if.tx_req) begin
                gnt_nxt = 1'b1;
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", mon_cur);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("beat", w_t'(mon_cur), w_t'(mon_exp));
                end
                beat_no = tx_if.tx_eop ? 0 : beat_no + 1;
                in_tlp = !tx_if.tx_eop;
                if (tx_if.tx_eop) begin
                    gnt_nxt = 1'b0;
                end
            end
            pop_pend = src_rd;
            if (src_rd) begin
                n_rd++;
            end
        end
    end

    // Environment: arbiter grant, tx_ready and source FIFO.
    initial begin
        tx_if.tx_gnt = 1'b0;
        tx_if.tx_ready = 1'b1;
        src_data = '0;
        src_level = '0;
        forever begin
            @(posedge clk_in);
            #1;
            tx_if.tx_gnt = rstn ? gnt_nxt : 1'b0;
            if (rstn && pop_pend && src_q.size() > 0) begin
                void'(src_q.pop_front());
            end
            tx_if.tx_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            src_data = (src_q.size() > 0) ? src_q[0] : 64'd0;
            src_level = (src_q.size() > 255) ? 8'd255 : 8'(src_q.size());
        end
    end

    task automatic reg_write(input logic idx, input logic [31:0] d);
        @(posedge clk_in);
        #1;
        reg_wr = 1'b1;
        reg_idx = idx;
        reg_data = d;
        @(posedge clk_in);
        #1;
        reg_wr = 1'b0;
    endtask

    task automatic plan_job(input logic [31:0] base, input int n, input int nfill);
        logic [31:0] a;
        logic [63:0] w;
        int k = 0;
        a = base + 32'd64;
        for (int t = 0; t < n; t++) begin
            for (int b = 0; b < 16; b++) begin
                w = {$urandom, $urandom};
                exp_q.push_back({a, 10'd32, w, (b == 0), (b == 15)});
                if (k < nfill) src_q.push_back(w);
                else late_q.push_back(w);
                k++;
            end
            a = a + 32'd128;
        end
        exp_q.push_back({base, 10'd2, 64'hCAFEF00DC0DEFACE, 1'b1, 1'b1});
        m_done = m_done + 32'd1;
    endtask

    task automatic start_job(input logic [31:0] raw, input int n,
                             input int nfill, output int rd0);
        reg_write(DMABASE_IDX, raw);
        m_base = raw & 32'hFFFF_FFF8;
        plan_job(m_base, n, nfill);
        rd0 = n_rd;
        reg_write(DMACTRL_IDX, 32'(n));
        chk("busy_rise", w_t'(busy), w_t'(1));
    endtask

    task automatic finish_job(input int n, input int rd0, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (!busy && exp_q.size() == 0) break;
        end
        chk("job_in_time", w_t'(i < budget), w_t'(1));
        chk("done_cnt", w_t'(done_cnt), w_t'(m_done));
        chk("src_rd_count", w_t'(n_rd - rd0), w_t'(16 * n));
        chk("busy_low", w_t'(busy), w_t'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0;
        int i;
        #1;
        chk("reset_state", w_t'({tx_if.tx_req, tx_if.tx_valid, tx_if.tx_sop,
            tx_if.tx_eop, src_rd, busy, err_busy_wr, done_cnt}), w_t'(0));
        repeat (3) @(posedge clk_in);
        #1;
        rstn = 1'b1;

        reg_write(DMACTRL_IDX, 32'h0000_0000);
        chk("ctrl_zero_ignored", w_t'(busy), w_t'(0));
        reg_write(DMACTRL_IDX, 32'h0005_0000);
        chk("ctrl_hi_bits_ignored", w_t'(busy), w_t'(0));
        chk("no_err_idle", w_t'(err_busy_wr), w_t'(0));

        start_job(32'h0000_0020, 1, 16, rd0);
        finish_job(1, rd0, 200);
        start_job(32'h0000_1000, 3, 48, rd0);
        finish_job(3, rd0, 400);
        start_job(32'hFFFF_FFC3, 2, 32, rd0);
        finish_job(2, rd0, 300);

        start_job(32'h0000_0300, 1, 15, rd0);
        repeat (50) begin
            @(negedge clk_in);
            chk("req_low_starved", w_t'(tx_if.tx_req), w_t'(0));
        end
        @(posedge clk_in);
        #1;
        src_q.push_back(late_q.pop_front());
        @(negedge clk_in);
        chk("req_on_data", w_t'(tx_if.tx_req), w_t'(1));
        finish_job(1, rd0, 200);

        rdy_rand = 1'b1;
        start_job($urandom, 4, 64, rd0);
        finish_job(4, rd0, 800);
        rdy_rand = 1'b0;

        start_job(32'h0000_4000, 2, 32, rd0);
        reg_write(DMACTRL_IDX, 32'd5);
        reg_write(DMABASE_IDX, 32'h0000_8888);
        chk("err_busy_wr", w_t'(err_busy_wr), w_t'(1));
        finish_job(2, rd0, 300);

        start_job(32'h0000_2000, 1, 16, rd0);
        for (i = 0; i < 200; i++) begin
            @(posedge clk_in);
            #3;
            if (tx_if.tx_valid && beat_no == 7) break;
        end
        chk("reach_beat7", w_t'(i < 200), w_t'(1));
        rstn = 1'b0;
        #1;
        chk("async_reset_out", w_t'({tx_if.tx_req, tx_if.tx_valid,
            tx_if.tx_sop, tx_if.tx_eop, src_rd, busy, err_busy_wr,
            done_cnt, tx_if.tx_addr, tx_if.tx_len_dw}), w_t'(0));
        chk("async_reset_data", w_t'(tx_if.tx_data), w_t'(0));
        exp_q.delete();
        src_q.delete();
        late_q.delete();
        m_done = '0;
        repeat (2) @(posedge clk_in);
        #1;
        rstn = 1'b1;

        for (int j = 0; j < 32; j++) begin
            start_job($urandom, 1, 16, rd0);
            finish_job(1, rd0, 200);
        end
        chk("done_32", w_t'(done_cnt), w_t'(32));
        chk("err_clear", w_t'(err_busy_wr), w_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_write_sequencer.md
Name: dma_write_sequencer

Overview:
FPGA-side controller that sequences the upstream DMA engine.
- Host programs a base address (DMABASE) and a TLP count (DMACTRL) through BAR0 register writes.
- The block then issues that many 128-byte memory-write TLPs from a local 64-bit source FIFO into host memory, followed by one 8-byte completion-token write.
- It sits between the BAR0 register decoder, the data-source FIFO and the TX-path arbiter shared with the completion generator.

Parameters:
QW_PER_TLP, 16, 64-bit beats per data TLP (128 bytes)
DATA_OFFSET, 64, byte offset of the first data TLP from DMABASE
CNT_W, 16, width of the DMACTRL TLP count
TOKEN, 64'hCAFEF00DC0DEFACE, completion token written at DMABASE

Ports:
clk_in  in  1  system clock, all logic rising-edge
rstn  in  1  asynchronous active-low reset
reg_wr  in  1  one-cycle BAR0 register write strobe
reg_idx  in  1  0=DMABASE, 1=DMACTRL
reg_data  in  32  register write data
src_data  in  64  source FIFO head word
src_level  in  8  source FIFO occupancy in QWs
src_rd  out  1  source FIFO pop, asserted on each accepted data beat
tx_req  out  1  request to TX arbiter
tx_gnt  in  1  grant from arbiter; held by arbiter until tx_eop is accepted
tx_addr  out  32  byte address of current TLP, stable from request to eop
tx_len_dw  out  10  TLP payload length in DW (32 for data, 2 for token)
tx_data  out  64  payload beat
tx_valid  out  1  beat valid
tx_ready  in  1  beat accepted when tx_valid & tx_ready
tx_sop  out  1  first beat of TLP
tx_eop  out  1  last beat of TLP
busy  out  1  high from accepted start until token beat accepted
done_cnt  out  32  count of completed DMA jobs, wraps
err_busy_wr  out  1  sticky: register write arrived while busy

Behaviour:
- Reset values: all outputs 0; base register 0; FSM in IDLE.
- Async reset mid-TLP: tx_valid drops immediately and the job is abandoned. The bench must reset the arbiter too.
- Registers:
  - DMABASE write latches reg_data with bits [2:0] forced to 0.
  - DMACTRL write with reg_data[CNT_W-1:0] != 0 starts a job on the next cycle; busy rises one cycle after the strobe.
  - DMACTRL write of 0 is ignored.
  - Any register write while busy is ignored and sets err_busy_wr. err_busy_wr is cleared only by reset.
- FSM:
  - IDLE -> DREQ on start. remaining = count; addr = base + DATA_OFFSET.
  - DREQ: tx_req = src_level >= QW_PER_TLP, so a TLP body never bubbles for lack of data. When tx_req & tx_gnt -> DBEAT.
  - DBEAT: tx_valid = 1, tx_data = src_data, src_rd = tx_valid & tx_ready. tx_sop on beat 0, tx_eop on beat QW_PER_TLP-1. On accepted eop:
    - addr += 8*QW_PER_TLP;
    - remaining -= 1;
    - go to DREQ if remaining != 0, else TREQ.
  - TREQ: tx_req = 1, tx_addr = base, tx_len_dw = 2. When tx_gnt -> TBEAT.
  - TBEAT: one beat with tx_data = TOKEN and tx_sop = tx_eop = 1. On accept: done_cnt += 1, busy falls, -> IDLE.
- tx_req deasserts in the cycle after grant is seen.
- tx_valid, tx_data, tx_sop and tx_eop hold stable while tx_ready is low.
- Address arithmetic is 32-bit modulo 2^32; wrap is allowed and not flagged.
- Count = 2^CNT_W - 1 is legal; remaining is CNT_W bits wide.
- Grant deasserted mid-packet is an arbiter protocol violation; behaviour is undefined.

Decomposition:
- Shared package dma_pkg: register indices DMABASE_IDX and DMACTRL_IDX, the TOKEN constant, QW_PER_TLP, DATA_OFFSET, and the FSM state enum (IDLE, DREQ, DBEAT, TREQ, TBEAT).
- No sub-module needed; one flat module with FSM, beat counter and address/remaining registers.

Test Plan:
- DMABASE=0x20, DMACTRL=1, src filled with 16 QWs, tx_ready=1, gnt on request -> one data TLP:
  - addr 0x60, len 32, 16 beats matching src;
  - then token TLP at 0x20 carrying 0xCAFEF00DC0DEFACE;
  - done_cnt=1, busy low.
- DMACTRL=3 with base 0x1000 -> data TLPs at 0x1040, 0x10C0, 0x1140, then token at 0x1000; exactly 48 src_rd pulses.
- src_level=15 for 50 cycles -> tx_req stays low; raise to 16 -> tx_req next cycle; no tx_valid gaps within the TLP.
- tx_ready toggled randomly (1 of 3 cycles low) -> beats unchanged while stalled; src_rd count equals accepted beats; sop/eop correct.
- DMACTRL written while busy -> job unaffected and err_busy_wr=1. Also 32 back-to-back single-TLP jobs -> done_cnt=32.
- rstn pulsed during beat 7 -> outputs 0 asynchronously; next job with DMACTRL=1 completes normally.
